// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipe_reg_chain elastic register chain.
//
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer in front of stage 0.
// The occupancy counter then has to cover one more entry, which count_w() accounts for.
//
// Contents:
//   pipe_ctrl_t  per-stage control bundle {valid, flush} handed to each pipe_stage
//   count_w()    width of the occupancy counter for a given stage count
package pipe_pkg;

  // Incoming valid from the previous stage (or the input port) plus this stage's flush.
  typedef struct packed {
    logic valid;
    logic flush;
  } pipe_ctrl_t;

  // Enough bits to represent every occupancy value, including the skid entry if present.
  function automatic int unsigned count_w(input int unsigned stages);
`ifdef PIPE_SKID_EN
    return $clog2(stages + 2);
`else
    return $clog2(stages + 1);
`endif
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid bit plus payload register of the elastic chain.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous reset, active-high; clears valid, payload to RST_DATA
//   i_load   stage may take the upstream contents this cycle (can_load)
//   i_ctrl   {valid of upstream contents, flush of this stage}
//   i_d      upstream payload
//   o_v      stage holds valid payload
//   o_q      stage payload
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  pipe_ctrl_t       i_ctrl,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_q
);

  logic             r_v;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v <= 1'b0;
      r_q <= RST_DATA;
    end else begin
      if (i_load) begin
        r_v <= i_ctrl.valid && !i_ctrl.flush;
      end else begin
        r_v <= r_v && !i_ctrl.flush;
      end
      // Payload only follows valid arrivals, so an emptied stage keeps its last value and the
      // data bus does not toggle on bubbles.
      if (i_load && i_ctrl.valid) begin
        r_q <= i_d;
      end
    end
  end

  assign o_v = r_v;
  assign o_q = r_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised elastic pipeline register chain with valid/ready back-pressure,
// per-stage flush and registered occupancy reporting. Empty stages always load, so bubbles
// collapse while the tail is stalled.
//
// Build option: PIPE_SKID_EN adds a one-entry skid buffer in front of stage 0. o_ready then
// comes from a register (no combinational i_ready -> o_ready path) and o_count includes the
// skid entry. Without the macro, o_ready is combinational from i_ready.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous reset, active-high; overrides flush and handshake
//   i_valid        upstream payload valid
//   i_data         upstream payload
//   o_ready        chain accepts i_data this cycle
//   o_valid        last stage holds valid payload
//   o_data         last stage payload
//   i_ready        downstream accepts o_data this cycle
//   i_flush        bit k kills stage k contents at next edge
//   o_stage_valid  valid bit of each stage
//   o_count        number of valid entries (registered)
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      STAGES   = 4,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_data,
  input  logic                         i_ready,
  input  logic [STAGES-1:0]            i_flush,
  output logic [STAGES-1:0]            o_stage_valid,
  output logic [count_w(STAGES)-1:0]   o_count
);

  localparam int unsigned COUNT_W = count_w(STAGES);

  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_v_next;
  logic [STAGES-1:0] w_moves;
  logic [STAGES-1:0] w_can_load;
  logic [WIDTH-1:0]  w_q [STAGES];

  // What stage 0 sees as its upstream: the input port, or the skid when it is occupied.
  logic              w_in_valid;
  logic [WIDTH-1:0]  w_in_data;

  logic [COUNT_W-1:0] w_count_next;
  logic [COUNT_W-1:0] r_count;

  // Ready ripples from the tail towards the head: a stage can load if it is empty or its
  // occupant leaves this cycle.
  always_comb begin
    logic down;
    down       = i_ready;
    w_moves    = '0;
    w_can_load = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      w_moves[k]    = w_v[k] && down;
      w_can_load[k] = !w_v[k] || w_moves[k];
      down          = w_can_load[k];
    end
  end

`ifdef PIPE_SKID_EN
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_skid_v_next;
  logic             w_skid_take;

  // Input is accepted whenever the skid is empty; it parks in the skid if stage 0 is blocked.
  assign w_skid_take = !r_skid_v && i_valid && !w_can_load[0];

  always_comb begin
    w_skid_v_next = 1'b0;
    if (r_skid_v) begin
      w_skid_v_next = !w_can_load[0] && !i_flush[0];
    end else begin
      w_skid_v_next = w_skid_take && !i_flush[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_skid_v    <= 1'b0;
      r_skid_data <= RST_DATA;
    end else begin
      r_skid_v <= w_skid_v_next;
      if (w_skid_take) begin
        r_skid_data <= i_data;
      end
    end
  end

  // The skid drains ahead of new input, which is held off while it is occupied.
  assign w_in_valid = r_skid_v || i_valid;
  assign w_in_data  = r_skid_v ? r_skid_data : i_data;
  assign o_ready    = !r_skid_v;
`else
  assign w_in_valid = i_valid;
  assign w_in_data  = i_data;
  assign o_ready    = w_can_load[0];
`endif

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             w_prev_v;
    logic [WIDTH-1:0] w_prev_q;
    pipe_ctrl_t       w_ctrl;

    if (g == 0) begin : g_head
      assign w_prev_v = w_in_valid;
      assign w_prev_q = w_in_data;
    end else begin : g_body
      assign w_prev_v = w_v[g-1];
      assign w_prev_q = w_q[g-1];
    end

    assign w_ctrl.valid = w_prev_v;
    assign w_ctrl.flush = i_flush[g];

    // Mirror of the stage's valid update so the occupancy can be registered alongside it.
    assign w_v_next[g] = w_can_load[g] ? (w_prev_v && !i_flush[g]) : (w_v[g] && !i_flush[g]);

    pipe_stage #(
      .WIDTH    (WIDTH),
      .RST_DATA (RST_DATA)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_can_load[g]),
      .i_ctrl (w_ctrl),
      .i_d    (w_prev_q),
      .o_v    (w_v[g]),
      .o_q    (w_q[g])
    );
  end

  always_comb begin
    w_count_next = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      w_count_next = w_count_next + COUNT_W'(w_v_next[k]);
    end
`ifdef PIPE_SKID_EN
    w_count_next = w_count_next + COUNT_W'(w_skid_v_next);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_valid       = w_v[STAGES-1];
  assign o_data        = w_q[STAGES-1];
  assign o_stage_valid = w_v;
  assign o_count       = r_count;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (STAGES=4, WIDTH=32). Accepted payloads that should survive are
// queued in order; a monitor pops and compares on every output transfer. Occupancy is tracked
// as accepted minus delivered during the random phase.
module tb_pipe_reg_chain;
  import pipe_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned CW     = count_w(STAGES);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic [WIDTH-1:0]  i_data = '0;
  logic              i_ready = 1'b0;
  logic [STAGES-1:0] i_flush = '0;
  logic              o_ready;
  logic              o_valid;
  logic [WIDTH-1:0]  o_data;
  logic [STAGES-1:0] o_stage_valid;
  logic [CW-1:0]     o_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int occ = 0;
  bit chk_occ = 1'b0;

  logic              s_valid, s_ready, s_acc;
  logic [STAGES-1:0] s_sv;
  logic [31:0]       s_count, s_data;

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH    (WIDTH),
    .STAGES   (STAGES),
    .RST_DATA (32'h0)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .i_ready       (i_ready),
    .i_flush       (i_flush),
    .o_stage_valid (o_stage_valid),
    .o_count       (o_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Output monitor: every output transfer must match the oldest expected payload.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected got=%h exp=none", o_data);
      end else begin
        check("out_data", o_data, exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; samples the state left by the previous edge.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                      input logic [STAGES-1:0] fl, input bit drop);
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    i_flush = fl;
    @(negedge clk);
    s_valid = o_valid;
    s_ready = o_ready;
    s_sv    = o_stage_valid;
    s_count = 32'(o_count);
    s_data  = o_data;
    s_acc   = v && o_ready;
    if (chk_occ) begin
      check("occupancy", s_count, occ);
`ifndef PIPE_SKID_EN
      check("ready_rule", 32'(o_ready), 32'((occ < int'(STAGES)) || rdy));
`endif
      occ = occ + int'(s_acc) - int'(o_valid && rdy);
    end
    if (s_acc && !drop && !rst) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, rdy, '0, 1'b0);
  endtask

  task automatic drain(input string name);
    repeat (STAGES + 4) idle(1'b1);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_count"}, s_count, 0);
  endtask

  initial begin
    int vexp[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int cexp[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    logic [31:0] sdat[3] = '{32'h11, 32'h22, 32'h33};

    // Reset state
    rst = 1'b1;
    repeat (2) idle(1'b0);
    rst = 1'b0;
    idle(1'b0);
    check("rst_valid", s_valid, 0);
    check("rst_count", s_count, 0);
    check("rst_ready", s_ready, 1);
    check("rst_sv", s_sv, 0);
    check("rst_data", s_data, 0);

    // Streaming: 4-cycle latency, back-to-back output
    for (int n = 0; n < 8; n++) begin
      if (n < 3) step(1'b1, sdat[n], 1'b1, '0, 1'b0);
      else idle(1'b1);
      check("stream_valid", s_valid, vexp[n]);
      check("stream_count", s_count, cexp[n]);
    end
    drain("stream");

    // Back-pressure
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hA0 + i, 1'b0, '0, 1'b0);
      check("bp_accept", s_acc, 1);
    end
`ifndef PIPE_SKID_EN
    step(1'b1, 32'hA4, 1'b0, '0, 1'b0);
    check("bp_held", s_acc, 0);
    check("bp_ready", s_ready, 0);
    check("bp_count", s_count, 4);
    check("bp_sv", s_sv, 4'hF);
    check("bp_ovalid", s_valid, 1);
`endif
    step(1'b1, 32'hA4, 1'b1, '0, 1'b0);
    check("bp_resume", s_acc, 1);
    drain("bp");

    // Bubble collapse
    step(1'b1, 32'h01, 1'b0, '0, 1'b0);
    repeat (2) idle(1'b0);
    step(1'b1, 32'h02, 1'b0, '0, 1'b0);
    repeat (4) idle(1'b0);
    check("bubble_sv", s_sv, 4'b1100);
    check("bubble_count", s_count, 2);
    drain("bubble");

    // Flush of the two youngest stages while stalled
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + i, 1'b0, '0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 4'b0011, 1'b0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    idle(1'b0);
    check("flush_sv", s_sv, 4'b1100);
    check("flush_count", s_count, 2);
    drain("flush");

    // Flush of stage 0 together with an input transfer: handshake completes, payload dropped
    step(1'b1, 32'hD0, 1'b1, 4'b0001, 1'b1);
    check("flush_in_acc", s_acc, 1);
    idle(1'b1);
    check("flush_in_sv", s_sv, 0);
    drain("flush_in");

    // Flush of stage 1 while 0xC5 moves out of it; 0xC6 moving in is dropped
    step(1'b1, 32'hC4, 1'b1, '0, 1'b0);
    step(1'b1, 32'hC5, 1'b1, '0, 1'b0);
    step(1'b1, 32'hC6, 1'b1, '0, 1'b1);
    step(1'b1, 32'hC7, 1'b1, 4'b0010, 1'b0);
    idle(1'b1);
    check("fmove_sv", s_sv, 4'b1101);
    check("fmove_count", s_count, 3);
    drain("fmove");

    // Random traffic against the in-order model
    occ = 0;
    chk_occ = 1'b1;
    repeat (400) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) < 6), '0, 1'b0);
    end
    chk_occ = 1'b0;
    drain("random");

    // Reset in the middle of a full chain
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + i, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'hEE, 1'b0, '0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    idle(1'b0);
    check("mid_rst_valid", s_valid, 0);
    check("mid_rst_count", s_count, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_data", s_data, 0);
    check("mid_rst_sv", s_sv, 0);
    drain("mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
